// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into NSTAGES ripple stages of SLICE bits each.
// One global stall; every transaction's operands and partial sum travel with its valid bit.

module pipelined_adder_stage #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int IDX   = 0,
  parameter int LAST  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [WIDTH-1:0] prv_a,
  input  logic [WIDTH-1:0] prv_b,
  input  logic [WIDTH-1:0] prv_sum,
  input  logic             prv_c,
  input  logic             prv_ov,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             ov
);
  localparam int LO = IDX * SLICE;
  localparam int HI = LO + SLICE - 1;

  logic [SLICE:0]   add;
  logic [WIDTH-1:0] sum_n;
  logic             ov_n;

  assign add = {1'b0, prv_a[LO +: SLICE]} + {1'b0, prv_b[LO +: SLICE]} + {{SLICE{1'b0}}, prv_c};

  always_comb begin
    sum_n = prv_sum;
    sum_n[LO +: SLICE] = add[SLICE-1:0];
  end

  // Carry into the word MSB is recovered from the MSB sum bit: a ^ b ^ s.
  assign ov_n = (LAST != 0) ? (prv_a[HI] ^ prv_b[HI] ^ add[SLICE-1] ^ add[SLICE]) : prv_ov;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      sum <= '0;
      c   <= 1'b0;
      ov  <= 1'b0;
    end else if (adv) begin
      a   <= prv_a;
      b   <= prv_b;
      sum <= sum_n;
      c   <= add[SLICE];
      ov  <= ov_n;
    end
  end
endmodule

module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_carry,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow
);
  localparam int NSTAGES = WIDTH / SLICE;

  logic                          adv;
  logic [NSTAGES:1]              vld_q;
  logic [NSTAGES:0]              vld_pipe;
  logic [NSTAGES:0][WIDTH-1:0]   a_p, b_p, s_p;
  logic [NSTAGES:0]              c_p, ov_p;
  logic                          unused_ok;

  // Whole pipe moves or whole pipe holds; bubbles are never squeezed out.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign vld_pipe = {vld_q, in_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[NSTAGES-1:0];
  end

  // Subtract is A + ~B + ~borrow.
  assign a_p[0]  = in_x;
  assign b_p[0]  = in_sub ? ~in_y : in_y;
  assign c_p[0]  = in_carry ^ in_sub;
  assign s_p[0]  = '0;
  assign ov_p[0] = 1'b0;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    pipelined_adder_stage #(
      .WIDTH (WIDTH),
      .SLICE (SLICE),
      .IDX   (k),
      .LAST  ((k == NSTAGES - 1) ? 1 : 0)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv),
      .prv_a   (a_p[k]),
      .prv_b   (b_p[k]),
      .prv_sum (s_p[k]),
      .prv_c   (c_p[k]),
      .prv_ov  (ov_p[k]),
      .a       (a_p[k+1]),
      .b       (b_p[k+1]),
      .sum     (s_p[k+1]),
      .c       (c_p[k+1]),
      .ov      (ov_p[k+1])
    );
  end

  assign out_valid    = vld_pipe[NSTAGES];
  assign out_sum      = s_p[NSTAGES];
  assign out_carry    = c_p[NSTAGES];
  assign out_overflow = ov_p[NSTAGES];

  // Operands are fully consumed by the last stage.
  assign unused_ok = ^{a_p[NSTAGES], b_p[NSTAGES]};
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, SLICE=4): reset, arithmetic corners,
// latency, backpressure streaming and mid-flight reset.
module tb_pipelined_adder;
  localparam int WIDTH = 16, SLICE = 4, NSTAGES = 4;

  logic             clk = 1'b0, rst = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0] in_x = '0, in_y = '0;
  logic             in_carry = 1'b0, in_sub = 1'b0;
  logic             out_valid, out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry, out_overflow;

  pipelined_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_carry(in_carry), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // {carry, overflow, sum}, hand-computed
  logic [15:0] vx [8], vy [8];
  logic        vc [8], vs [8];
  logic [17:0] vexp [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i);
    in_x = vx[i]; in_y = vy[i]; in_carry = vc[i]; in_sub = vs[i];
  endtask

  task automatic scramble();
    in_x = 16'($urandom); in_y = 16'($urandom);
    in_carry = 1'($urandom); in_sub = 1'($urandom);
  endtask

  function automatic logic [31:0] res();
    return {14'd0, out_carry, out_overflow, out_sum};
  endfunction

  // Called #1 after the accept edge; counts cycles until out_valid.
  task automatic wait_result(input int i);
    int lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("lat%0d", i), lat, NSTAGES);
    chk($sformatf("res%0d", i), res(), {14'd0, vexp[i]});
  endtask

  task automatic send(input int i);
    @(posedge clk); #1;
    drive(i); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("rdy%0d", i), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; scramble();
    wait_result(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        seen;
    int          idx_in, idx_out;

    vx[0]=16'hFFFF; vy[0]=16'h0001; vc[0]=0; vs[0]=0; vexp[0]=18'h20000;
    vx[1]=16'h7FFF; vy[1]=16'h0001; vc[1]=0; vs[1]=0; vexp[1]=18'h18000;
    vx[2]=16'h8000; vy[2]=16'h0001; vc[2]=0; vs[2]=1; vexp[2]=18'h37FFF;
    vx[3]=16'h0000; vy[3]=16'h0000; vc[3]=1; vs[3]=1; vexp[3]=18'h0FFFF;
    vx[4]=16'h1234; vy[4]=16'h4321; vc[4]=1; vs[4]=0; vexp[4]=18'h05556;
    vx[5]=16'h0005; vy[5]=16'h0003; vc[5]=0; vs[5]=1; vexp[5]=18'h20002;
    vx[6]=16'h8000; vy[6]=16'h8000; vc[6]=0; vs[6]=0; vexp[6]=18'h30000;
    vx[7]=16'h00FF; vy[7]=16'h0F01; vc[7]=0; vs[7]=0; vexp[7]=18'h01000;

    // Reset with live random traffic presented.
    in_valid = 1'b1; scramble(); out_ready = 1'($urandom);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      scramble();
    end
    chk("rst_vld", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_carry", out_carry, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_rdy", in_ready, 1);

    // Release between edges with a transaction waiting: first edge accepts it.
    @(negedge clk);
    rst = 1'b0; drive(0); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; scramble();
    wait_result(0);

    for (int i = 1; i < 8; i++) send(i);

    // Back-to-back stream with a 3-cycle downstream stall.
    idx_in = 0; idx_out = 0; held = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60 && idx_out < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (idx_in < 8);
      if (idx_in < 8) drive(idx_in); else scramble();
      @(negedge clk);
      if (!out_ready) begin
        chk($sformatf("bp_rdy%0d", cyc), in_ready, 0);
        chk($sformatf("bp_vld%0d", cyc), out_valid, 1);
        if (cyc == 6) held = res();
        else chk($sformatf("bp_hold%0d", cyc), res(), held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d", idx_out), res(), {14'd0, vexp[idx_out]});
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_cnt", idx_out, 8);

    // Reset with three transactions in flight.
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      drive(4 + j); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_vld", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_vld", out_valid, 0);
    chk("async_sum", out_sum, 0);
    in_valid = 1'b1; scramble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_flush", seen, 0);
    send(7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand and sum width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter: SLICE, 4, bits added per pipeline stage; NSTAGES = WIDTH/SLICE, and NSTAGES >= 1.
REQ-003 Port: clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand transaction present.
REQ-006 Port: in_ready  output  1  block accepts the transaction this cycle.
REQ-007 Port: in_x  input  WIDTH  operand A.
REQ-008 Port: in_y  input  WIDTH  operand B.
REQ-009 Port: in_carry  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 Port: in_sub  input  1  0 = A+B+cin; 1 = A-B-borrow.
REQ-011 Port: out_valid  output  1  result present at the output stage.
REQ-012 Port: out_ready  input  1  downstream consumes the result this cycle.
REQ-013 Port: out_sum  output  WIDTH  result.
REQ-014 Port: out_carry  output  1  carry-out of the MSB (subtract: 1 = no borrow).
REQ-015 Port: out_overflow  output  1  two's-complement signed overflow.

Function
REQ-016 Effective B SHALL be ~in_y when in_sub=1, else in_y; effective cin SHALL be ~in_carry when in_sub=1, else in_carry.
REQ-017 Stage k (0..NSTAGES-1) SHALL add slice k of A and effective B plus the carry registered from stage k-1 (stage 0 uses effective cin), and SHALL register the slice sum and carry-out.
REQ-018 Stages SHALL carry the not-yet-added upper slices and the already-computed lower sum bits forward, so that each transaction's operands travel with it.
REQ-019 advance = !out_valid || out_ready; in_ready SHALL equal advance combinationally.
REQ-020 A transaction SHALL be accepted only in a cycle where in_valid && in_ready.
REQ-021 When advance=1, every stage register, including its valid bit, SHALL shift one stage. When advance=0, all stages SHALL hold.
REQ-022 Bubbles SHALL be shifted like data; the global stall SHALL NOT collapse bubbles.
REQ-023 Latency: a result accepted in cycle t SHALL appear with out_valid=1 in cycle t+NSTAGES, provided there is no stall; each stall cycle SHALL add one cycle.
REQ-024 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-025 out_sum, out_carry and out_overflow SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 out_overflow SHALL equal (carry into the MSB) XOR (carry out of the MSB) for the full WIDTH-bit operation.
REQ-027 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.
REQ-028 Simultaneous accept and output consume in the same cycle SHALL lose no data and duplicate none.
REQ-029 in_x, in_y, in_carry and in_sub SHALL be ignored when in_valid=0 or in_ready=0.
REQ-030 NSTAGES=1 SHALL give a single registered WIDTH-bit adder with latency 1.

Reset
REQ-031 While rst=1, all stage valid bits SHALL be 0, and out_valid, out_sum, out_carry and out_overflow SHALL be 0, asynchronously.
REQ-032 Reset asserted mid-operation SHALL discard every in-flight transaction; no partial result SHALL appear after release.
REQ-033 During reset, in_ready SHALL be 1, since out_valid=0; transactions presented while rst=1 SHALL NOT be accepted.
REQ-034 The first accept SHALL occur on the first rising clk edge with rst=0.

Verification (WIDTH=16, SLICE=4, NSTAGES=4)
REQ-035 Reset: assert rst with random inputs -> out_valid=0, out_sum=0x0000, out_carry=0, out_overflow=0, in_ready=1.
REQ-036 Add wrap: 0xFFFF+0x0001, cin=0, out_ready=1 -> 4 cycles later out_sum=0x0000, carry=1, overflow=0.
REQ-037 Signed overflow: 0x7FFF+0x0001, cin=0 -> 0x8000, carry=0, overflow=1; sub 0x8000-0x0001, borrow=0 -> 0x7FFF, carry=1, overflow=1.
REQ-038 Borrow chain: sub 0x0000-0x0000 with borrow=1 -> 0xFFFF, carry=0, overflow=0.
REQ-039 Backpressure: stream 8 back-to-back adds, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 for those cycles, outputs held, all 8 results delivered in order and correct.
REQ-040 Reset mid-flight: accept 3 transactions, assert rst on the next cycle, release -> no out_valid until a new transaction is accepted, then its result appears 4 cycles later.
